// File: rtl/multicycle_controller.sv
// multicycle_controller: sequencing FSM for the multi-cycle MIPS-subset datapath.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   opcode            IR[31:26], valid from DECODE onward
//   zero              ALU zero flag (consumed by the datapath via pc_write_cond)
//   mem_ready         memory completes the current access this cycle
//   pc_write .. pc_source   datapath enables and mux selects
//   state             current FSM state (debug)
//   retire            pulse in the last cycle of each instruction
//   halted            sticky illegal-opcode flag
//   instr_count       retired-instruction counter (wraps silently)
module multicycle_controller #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic [3:0]       state,
   output logic             retire,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);
   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
      BRANCH = 4'd8,
      ADDIEX = 4'd9,
      ADDIWB = 4'd10,
      JUMP   = 4'd11,
      HALT   = 4'd12
   } state_t;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
   state_t state_q, state_d;
   logic halted_q;
   logic [CNT_W-1:0] cnt_q;
   // zero is applied by the datapath through pc_write_cond; the FSM does not branch on it
   logic unused_zero;
   assign unused_zero = zero;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= FETCH;
         halted_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         halted_q <= halted_q | (state_d == HALT);
         cnt_q    <= cnt_q + CNT_W'(retire);
      end
   end
   // Every output is zero while reset is high so no partial write leaks out.
   always_comb begin
      state_d       = state_q;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      retire        = 1'b0;
      if (!reset) begin
         case (state_q)
            FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
               state_d   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
               alu_src_b = 2'b11;
               case (opcode)
                  OP_LW, OP_SW: state_d = MEMADR;
                  OP_R:         state_d = EXEC;
                  OP_BEQ:       state_d = BRANCH;
                  OP_ADDI:      state_d = ADDIEX;
                  OP_J:         state_d = JUMP;
                  default:      state_d = HALT;
               endcase
            end
            MEMADR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               state_d   = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
               mem_read = 1'b1;
               iord     = 1'b1;
               state_d  = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
               retire     = 1'b1;
               state_d    = FETCH;
            end
            MEMWR: begin
               mem_write = 1'b1;
               iord      = 1'b1;
               retire    = mem_ready;
               state_d   = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b10;
               state_d   = ALUWB;
            end
            ALUWB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
               retire    = 1'b1;
               state_d   = FETCH;
            end
            BRANCH: begin
               alu_src_a     = 1'b1;
               alu_op        = 2'b01;
               pc_write_cond = 1'b1;
               pc_source     = 2'b01;
               retire        = 1'b1;
               state_d       = FETCH;
            end
            ADDIEX: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               state_d   = ADDIWB;
            end
            ADDIWB: begin
               reg_write = 1'b1;
               retire    = 1'b1;
               state_d   = FETCH;
            end
            JUMP: begin
               pc_write  = 1'b1;
               pc_source = 2'b10;
               retire    = 1'b1;
               state_d   = FETCH;
            end
            default: state_d = HALT;
         endcase
      end
   end
   assign state       = reset ? 4'd0 : state_q;
   assign halted      = halted_q & ~reset;
   assign instr_count = reset ? '0 : cnt_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed table-driven check of multicycle_controller.
module tb_multicycle_controller;
   logic clk = 1'b0;
   logic reset, zero, mem_ready;
   logic [5:0] opcode;
   logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic mem_to_reg, reg_dst, reg_write, alu_src_a, retire, halted;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic [3:0] state, instr_count;
   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   multicycle_controller #(.CNT_W(4)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .state(state), .retire(retire), .halted(halted),
      .instr_count(instr_count)
   );

   // control word: pc_write pc_write_cond iord mem_read mem_write ir_write
   //               mem_to_reg reg_dst reg_write alu_src_a alu_src_b alu_op pc_source retire halted
   localparam logic [17:0] C_ZERO   = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
   localparam logic [17:0] C_FR     = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
   localparam logic [17:0] C_FS     = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
   localparam logic [17:0] C_DEC    = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
   localparam logic [17:0] C_MEMADR = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
   localparam logic [17:0] C_MEMRD  = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
   localparam logic [17:0] C_MEMWB  = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
   localparam logic [17:0] C_WRS    = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
   localparam logic [17:0] C_WRR    = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
   localparam logic [17:0] C_EXEC   = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
   localparam logic [17:0] C_ALUWB  = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
   localparam logic [17:0] C_BRANCH = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
   localparam logic [17:0] C_ADDIEX = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
   localparam logic [17:0] C_ADDIWB = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;
   localparam logic [17:0] C_JUMP   = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
   localparam logic [17:0] C_HALT   = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_1;

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic        z;
      logic        mr;
      logic [3:0]  st;
      logic [17:0] ctl;
      logic [3:0]  cnt;
   } vec_t;

   vec_t vecs[38];

   function automatic logic [17:0] actual_ctl();
      return {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
              mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
              pc_source, retire, halted};
   endfunction

   task automatic check(input string name, input logic [3:0] st, input logic [17:0] ctl, input logic [3:0] cnt);
      n_checks++;
      if (state !== st || actual_ctl() !== ctl || instr_count !== cnt) begin
         n_fail++;
         $display("FAIL %s: got state=%0d ctl=%b cnt=%0d, want state=%0d ctl=%b cnt=%0d",
                  name, state, actual_ctl(), instr_count, st, ctl, cnt);
      end
   endtask

   // apply inputs after the falling edge, sample 1 ns later, then let the rising edge happen
   task automatic cyc(input logic r, input logic [5:0] op, input logic z, input logic mr);
      @(negedge clk);
      reset = r; opcode = op; zero = z; mem_ready = mr;
      #1;
   endtask

   initial begin
      reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
      //          rst  op          z     mr    st     ctl       cnt
      vecs[0]  = '{1'b1, 6'b000000, 1'b0, 1'b1, 4'd0,  C_ZERO,   4'd0};
      vecs[1]  = '{1'b0, 6'b000000, 1'b0, 1'b1, 4'd0,  C_FR,     4'd0};
      vecs[2]  = '{1'b0, 6'b000000, 1'b0, 1'b1, 4'd1,  C_DEC,    4'd0};
      vecs[3]  = '{1'b0, 6'b000000, 1'b0, 1'b1, 4'd6,  C_EXEC,   4'd0};
      vecs[4]  = '{1'b0, 6'b000000, 1'b0, 1'b1, 4'd7,  C_ALUWB,  4'd0};
      vecs[5]  = '{1'b0, 6'b100011, 1'b0, 1'b1, 4'd0,  C_FR,     4'd1};
      vecs[6]  = '{1'b0, 6'b100011, 1'b0, 1'b1, 4'd1,  C_DEC,    4'd1};
      vecs[7]  = '{1'b0, 6'b100011, 1'b0, 1'b1, 4'd2,  C_MEMADR, 4'd1};
      vecs[8]  = '{1'b0, 6'b100011, 1'b0, 1'b0, 4'd3,  C_MEMRD,  4'd1};
      vecs[9]  = '{1'b0, 6'b100011, 1'b0, 1'b0, 4'd3,  C_MEMRD,  4'd1};
      vecs[10] = '{1'b0, 6'b100011, 1'b0, 1'b1, 4'd3,  C_MEMRD,  4'd1};
      vecs[11] = '{1'b0, 6'b100011, 1'b0, 1'b1, 4'd4,  C_MEMWB,  4'd1};
      vecs[12] = '{1'b0, 6'b101011, 1'b0, 1'b1, 4'd0,  C_FR,     4'd2};
      vecs[13] = '{1'b0, 6'b101011, 1'b0, 1'b1, 4'd1,  C_DEC,    4'd2};
      vecs[14] = '{1'b0, 6'b101011, 1'b0, 1'b1, 4'd2,  C_MEMADR, 4'd2};
      vecs[15] = '{1'b0, 6'b101011, 1'b0, 1'b1, 4'd5,  C_WRR,    4'd2};
      vecs[16] = '{1'b0, 6'b000100, 1'b1, 1'b1, 4'd0,  C_FR,     4'd3};
      vecs[17] = '{1'b0, 6'b000100, 1'b1, 1'b1, 4'd1,  C_DEC,    4'd3};
      vecs[18] = '{1'b0, 6'b000100, 1'b1, 1'b1, 4'd8,  C_BRANCH, 4'd3};
      vecs[19] = '{1'b0, 6'b001000, 1'b0, 1'b1, 4'd0,  C_FR,     4'd4};
      vecs[20] = '{1'b0, 6'b001000, 1'b0, 1'b1, 4'd1,  C_DEC,    4'd4};
      vecs[21] = '{1'b0, 6'b001000, 1'b0, 1'b1, 4'd9,  C_ADDIEX, 4'd4};
      vecs[22] = '{1'b0, 6'b001000, 1'b0, 1'b1, 4'd10, C_ADDIWB, 4'd4};
      vecs[23] = '{1'b0, 6'b000010, 1'b0, 1'b0, 4'd0,  C_FS,     4'd5};
      vecs[24] = '{1'b0, 6'b000010, 1'b0, 1'b1, 4'd0,  C_FR,     4'd5};
      vecs[25] = '{1'b0, 6'b000010, 1'b0, 1'b1, 4'd1,  C_DEC,    4'd5};
      vecs[26] = '{1'b0, 6'b000010, 1'b0, 1'b1, 4'd11, C_JUMP,   4'd5};
      vecs[27] = '{1'b0, 6'b111111, 1'b0, 1'b1, 4'd0,  C_FR,     4'd6};
      vecs[28] = '{1'b0, 6'b111111, 1'b0, 1'b1, 4'd1,  C_DEC,    4'd6};
      vecs[29] = '{1'b0, 6'b111111, 1'b0, 1'b0, 4'd12, C_HALT,   4'd6};
      vecs[30] = '{1'b0, 6'b000000, 1'b1, 1'b1, 4'd12, C_HALT,   4'd6};
      vecs[31] = '{1'b1, 6'b101011, 1'b0, 1'b1, 4'd0,  C_ZERO,   4'd0};
      vecs[32] = '{1'b0, 6'b101011, 1'b0, 1'b1, 4'd0,  C_FR,     4'd0};
      vecs[33] = '{1'b0, 6'b101011, 1'b0, 1'b1, 4'd1,  C_DEC,    4'd0};
      vecs[34] = '{1'b0, 6'b101011, 1'b0, 1'b1, 4'd2,  C_MEMADR, 4'd0};
      vecs[35] = '{1'b0, 6'b101011, 1'b0, 1'b0, 4'd5,  C_WRS,    4'd0};
      vecs[36] = '{1'b1, 6'b101011, 1'b0, 1'b0, 4'd0,  C_ZERO,   4'd0};
      vecs[37] = '{1'b0, 6'b101011, 1'b0, 1'b0, 4'd0,  C_FS,     4'd0};
      for (int i = 0; i < 38; i++) begin
         cyc(vecs[i].rst, vecs[i].op, vecs[i].z, vecs[i].mr);
         check($sformatf("vec%0d", i), vecs[i].st, vecs[i].ctl, vecs[i].cnt);
      end
      // illegal opcode: HALT holds for 20 cycles whatever mem_ready/opcode do
      cyc(1'b1, 6'b111111, 1'b0, 1'b1);
      cyc(1'b0, 6'b111111, 1'b0, 1'b1);
      check("halt_fetch", 4'd0, C_FR, 4'd0);
      cyc(1'b0, 6'b111111, 1'b0, 1'b1);
      check("halt_decode", 4'd1, C_DEC, 4'd0);
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         check($sformatf("halt_hold%0d", i), 4'd12, C_HALT, 4'd0);
      end
      cyc(1'b1, 6'b000010, 1'b0, 1'b1);
      check("halt_reset", 4'd0, C_ZERO, 4'd0);
      // 16 jumps: 4-bit counter walks 0..15 and wraps to 0
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 6'b000010, 1'b0, 1'b1);
         check($sformatf("j%0d_fetch", i), 4'd0, C_FR, 4'(i));
         cyc(1'b0, 6'b000010, 1'b0, 1'b1);
         check($sformatf("j%0d_decode", i), 4'd1, C_DEC, 4'(i));
         cyc(1'b0, 6'b000010, 1'b0, 1'b1);
         check($sformatf("j%0d_jump", i), 4'd11, C_JUMP, 4'(i));
      end
      cyc(1'b0, 6'b000010, 1'b0, 1'b0);
      check("j_wrap", 4'd0, C_FS, 4'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing FSM for the multi-cycle version of the MIPS-subset datapath: the shared memory, ALU, register file, IR and PC are reused across 3-5 cycles per instruction.
- Decodes the opcode held in the IR and drives every datapath enable and mux select each cycle.
- Stalls on a memory ready handshake, halts on illegal opcodes, and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- opcode  input  6  IR[31:26]; valid from DECODE onward.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current read/write this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if zero.
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  IR load.
- mem_to_reg  output  1  writeback data select: 1 = MDR, 0 = ALUOut.
- reg_dst  output  1  destination register: 1 = rd, 0 = rt.
- reg_write  output  1  register file write.
- alu_src_a  output  1  ALU A input: 0 = PC, 1 = register A.
- alu_src_b  output  2  ALU B input: 00 = register B, 01 = PC increment constant, 10 = sign-extended imm, 11 = shifted imm.
- alu_op  output  2  00 = add, 01 = sub, 10 = funct-decoded.
- pc_source  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  output  4  current state encoding (debug).
- retire  output  1  one-cycle pulse in the last cycle of each instruction.
- halted  output  1  illegal opcode seen; sticky until reset.
- instr_count  output  CNT_W  retired-instruction count.

Behaviour:
- Opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - addi 001000
  - j 000010
  - any other value is illegal.
- State encoding: FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11, HALT = 12.
- Outputs are combinational from state (plus mem_ready in memory states). Every output not listed for a state is 0.
- FETCH:
  - mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - If mem_ready: ir_write = 1, pc_write = 1, next state DECODE.
  - Else: stay in FETCH with ir_write = 0 and pc_write = 0.
- DECODE:
  - alu_src_a = 0, alu_src_b = 11, alu_op = 00 (precomputes the branch target).
  - Next state: lw/sw -> MEMADR, R-type -> EXEC, beq -> BRANCH, addi -> ADDIEX, j -> JUMP, illegal -> HALT.
- MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next state MEMRD for lw, MEMWR for sw.
- MEMRD:
  - mem_read = 1, iord = 1.
  - Stay until mem_ready, then go to MEMWB.
- MEMWB: reg_write = 1, mem_to_reg = 1, reg_dst = 0, retire = 1. Next state FETCH.
- MEMWR:
  - mem_write = 1, iord = 1.
  - Stay until mem_ready. In the mem_ready cycle, retire = 1 and next state is FETCH.
- EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Next state ALUWB.
- ALUWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0, retire = 1. Next state FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01, retire = 1. Next state FETCH.
- ADDIEX: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next state ADDIWB.
- ADDIWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0, retire = 1. Next state FETCH.
- JUMP: pc_write = 1, pc_source = 10, retire = 1. Next state FETCH.
- HALT:
  - All outputs 0, halted = 1.
  - Stays in HALT until reset; mem_ready and opcode are ignored.
- instr_count:
  - Increments by 1 on each clock edge with retire = 1.
  - Wraps from all-ones to 0 with no flag.
  - HALT entry does not count as a retirement.
- Latency in cycles, assuming mem_ready is asserted in the first memory cycle: R-type 4, addi 4, lw 5, sw 4, beq 3, j 3. Each cycle with mem_ready low adds exactly 1 cycle.
- Reset:
  - While reset = 1, all outputs are forced to 0, including the mem_ready-qualified ones.
  - At the clock edge: state <= FETCH, instr_count <= 0, halted <= 0.
  - Reset takes precedence in every state, including mid-stall in MEMRD/MEMWR and HALT. No partial register or memory write is issued in the reset cycle.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.

Test Plan:
- R-type (opcode 000000), mem_ready tied to 1 -> state sequence 0, 1, 6, 7, 0. reg_write = 1 and reg_dst = 1 only in state 7. instr_count 0 -> 1 after 4 cycles.
- lw (100011), mem_ready held low for 2 cycles in MEMRD -> sequence 0, 1, 2, 3, 3, 3, 4, 0. mem_read = 1 and iord = 1 on all three MEMRD cycles. Total 7 cycles; retire only in state 4.
- sw (101011) followed by beq (000100) with zero = 1 -> sw: mem_write pulses in state 5 only, 4 cycles. beq: pc_write_cond = 1, pc_source = 01 and alu_op = 01 in state 8; 3 cycles. instr_count = 2.
- Illegal opcode 111111 -> DECODE goes to HALT (12). halted = 1 and all other outputs 0 for 20 cycles regardless of mem_ready; instr_count unchanged. Reset -> FETCH, halted = 0.
- Reset asserted during a MEMWR stall (mem_ready = 0) -> mem_write = 0 in the reset cycle; state = 0 and instr_count = 0 on the next cycle.
- CNT_W = 4, 16 j instructions (000010) -> instr_count wraps 15 -> 0. Each j takes 3 cycles with pc_write = 1 and pc_source = 10 in state 11.
